// File: rtl/spram_fifo_ctrl.sv
// Word FIFO on a 1-port RAM with a 2-entry output buffer. Latency 3 cycles from empty; in_ready drops when RAM full or a read wins arbitration.
// Optional sticky protocol-error detection under `define SPRAM_FIFO_ERR_EN (err tied low otherwise).
module spram_fifo_ctrl #(
    parameter int AWIDTH    = 11,
    parameter int DWIDTH    = 40,
    parameter int NUM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic [AWIDTH:0]   level,
    output logic [AWIDTH-1:0] ram_address,
    output logic              ram_wren,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_out,
    output logic              err
);
    typedef enum logic {PREF_WR = 1'b0, PREF_RD = 1'b1} rr_e;

    localparam logic [AWIDTH:0]   DEPTH    = (AWIDTH+1)'(NUM_WORDS);
    localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'(NUM_WORDS - 1);

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   ram_words_q, ram_words_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        obuf_cnt_q, obuf_cnt_d;
    logic [DWIDTH-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;
    rr_e               rr_q, rr_d;
    logic [AWIDTH:0]   level_q, level_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;

    logic ram_not_full, read_req, write_req, grant_rd, grant_wr, pop;

    assign ram_not_full = (ram_words_q < DEPTH);
    assign read_req     = (ram_words_q != '0) && ((obuf_cnt_q + {1'b0, inflight_q}) < 2'd2);
    assign write_req    = in_valid && ram_not_full;
    assign grant_rd     = read_req && (!write_req || rr_q == PREF_RD);
    assign grant_wr     = write_req && (!read_req || rr_q == PREF_WR);
    assign pop          = (obuf_cnt_q != 2'd0) && out_ready;

    // Independent of in_valid: the read wins only when it is its turn.
    assign in_ready    = ram_not_full && !(read_req && rr_q == PREF_RD);
    assign out_valid   = (obuf_cnt_q != 2'd0);
    assign out_data    = obuf0_q;
    assign level       = level_q;
    assign ram_wren    = grant_wr;
    assign ram_address = addr_d;
    assign ram_data    = wdata_d;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_words_d = ram_words_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        inflight_d  = grant_rd;

        if (read_req && write_req) begin
            rr_d = (rr_q == PREF_WR) ? PREF_RD : PREF_WR;
        end

        if (grant_wr) begin
            addr_d      = wr_ptr_q;
            wdata_d     = in_data;
            wr_ptr_d    = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            ram_words_d = ram_words_q + 1'b1;
        end else if (grant_rd) begin
            addr_d      = rd_ptr_q;
            rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            ram_words_d = ram_words_q - 1'b1;
        end
    end

    // Pop shifts first, so a same-cycle capture lands behind whatever remains.
    always_comb begin
        obuf0_d    = obuf0_q;
        obuf1_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q;
        if (pop) begin
            obuf0_d    = obuf1_q;
            obuf_cnt_d = obuf_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (obuf_cnt_d == 2'd0) begin
                obuf0_d = ram_out;
            end else begin
                obuf1_d = ram_out;
            end
            obuf_cnt_d = obuf_cnt_d + 2'd1;
        end
    end

    assign level_d = ram_words_d + (AWIDTH+1)'(inflight_d) + (AWIDTH+1)'(obuf_cnt_d);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_words_q <= '0;
            inflight_q  <= 1'b0;
            obuf_cnt_q  <= 2'd0;
            obuf0_q     <= '0;
            obuf1_q     <= '0;
            rr_q        <= PREF_WR;
            level_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_words_q <= ram_words_d;
            inflight_q  <= inflight_d;
            obuf_cnt_q  <= obuf_cnt_d;
            obuf0_q     <= obuf0_d;
            obuf1_q     <= obuf1_d;
            rr_q        <= rr_d;
            level_q     <= level_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef SPRAM_FIFO_ERR_EN
    logic [8:0] stall_cnt_q, stall_cnt_d;
    logic       err_q, err_d, ov_q, ordy_q, stall;

    assign stall = in_valid && !in_ready;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!stall) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != 9'd256) begin
            stall_cnt_d = stall_cnt_q + 9'd1;
        end
        // 256th consecutive stall cycle, or a word withdrawn without being taken.
        err_d = err_q || (stall && stall_cnt_q >= 9'd255) || (ov_q && !ordy_q && !out_valid);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
            ov_q        <= 1'b0;
            ordy_q      <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            ov_q        <= out_valid;
            ordy_q      <= out_ready;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl with a behavioural registered-read single-port RAM.
module tb_spram_fifo_ctrl;
    localparam int AW = 11;
    localparam int DW = 40;
    localparam int NW = 2048;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, ram_wren, err;
    logic [DW-1:0] out_data, ram_data;
    logic [DW-1:0] ram_out = '0;
    logic [AW:0]   level;
    logic [AW-1:0] ram_address;

    logic [DW-1:0] mem [0:NW-1];

    int vectors = 0;
    int miscompares = 0;

    spram_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_data(ram_data), .ram_out(ram_out), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        else          ram_out <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e, budget, pushes, pops, model;
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_w;
        logic [63:0]   r64;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ram_wren", 64'(ram_wren), 64'd0);
        chk("rst_ram_address", 64'(ram_address), 64'd0);
        chk("rst_ram_data", 64'(ram_data), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // Single word, minimum latency
        next_cycle();
        resetn = 1'b1;
        in_valid = 1'b1;
        in_data = 40'hA5A5A5A5A5;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_wr_wren", 64'(ram_wren), 64'd1);
        chk("t1_wr_addr", 64'(ram_address), 64'd0);
        chk("t1_wr_data", 64'(ram_data), 64'hA5A5A5A5A5);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_c1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_c1_rd_wren", 64'(ram_wren), 64'd0);
        chk("t1_c1_rd_addr", 64'(ram_address), 64'd0);
        chk("t1_c1_level", 64'(level), 64'd1);
        next_cycle();
        @(negedge clk);
        chk("t1_c2_out_valid", 64'(out_valid), 64'd0);
        chk("t1_c2_idle_data", 64'(ram_data), 64'hA5A5A5A5A5);
        next_cycle();
        @(negedge clk);
        chk("t1_c3_out_valid", 64'(out_valid), 64'd1);
        chk("t1_c3_out_data", 64'(out_data), 64'hA5A5A5A5A5);
        next_cycle();
        @(negedge clk);
        chk("t1_c4_out_valid", 64'(out_valid), 64'd0);
        chk("t1_c4_level", 64'(level), 64'd0);

        // Fill to capacity with no downstream, then drain
        next_cycle();
        out_ready = 1'b0;
        in_valid = 1'b1;
        n = 0;
        budget = 0;
        while (n < NW + 2 && budget < 5000) begin
            in_data = DW'(n);
            @(negedge clk);
            if (in_ready) n++;
            next_cycle();
            budget++;
        end
        if (n != NW + 2) timeout("t2_fill");
        in_data = '0;
        @(negedge clk);
        chk("t2_full_in_ready", 64'(in_ready), 64'd0);
        chk("t2_full_level", 64'(level), 64'(NW + 2));
        next_cycle();
        @(negedge clk);
        chk("t2_full_in_ready_hold", 64'(in_ready), 64'd0);
        chk("t2_full_wren", 64'(ram_wren), 64'd0);
        next_cycle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        e = 0;
        budget = 0;
        while (e < NW + 2 && budget < 10000) begin
            @(negedge clk);
            if (out_valid) begin
                chk("t2_drain_order", 64'(out_data), 64'(e));
                e++;
            end
            next_cycle();
            budget++;
        end
        if (e != NW + 2) timeout("t2_drain");
        next_cycle();
        @(negedge clk);
        chk("t2_empty_level", 64'(level), 64'd0);
        chk("t2_empty_out_valid", 64'(out_valid), 64'd0);

        // Continuous streaming across pointer wrap
        next_cycle();
        in_valid = 1'b1;
        out_ready = 1'b1;
        pushes = 0;
        pops = 0;
        for (int c = 0; c < 10000; c++) begin
            in_data = DW'(pushes);
            @(negedge clk);
            if (out_valid) begin
                chk("t3_stream_order", 64'(out_data), 64'(pops));
                pops++;
            end
            if (in_ready) pushes++;
            next_cycle();
        end
        in_valid = 1'b0;
        budget = 0;
        while (pops < pushes && budget < 50) begin
            @(negedge clk);
            if (out_valid) begin
                chk("t3_tail_order", 64'(out_data), 64'(pops));
                pops++;
            end
            next_cycle();
            budget++;
        end
        if (pops != pushes) timeout("t3_tail");
        chk("t3_alternating_rate", 64'(pushes >= 4995 && pushes <= 5005), 64'd1);

        // Reset while a read is in flight
        in_valid = 1'b1;
        in_data = 40'h0000000111;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_push_ready", 64'(in_ready), 64'd1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_read_issue", 64'(ram_wren), 64'd0);
        next_cycle();
        resetn = 1'b0;
        #1;
        chk("t4_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_level", 64'(level), 64'd0);
        next_cycle();
        resetn = 1'b1;
        in_valid = 1'b1;
        in_data = 40'h0000000222;
        out_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        in_valid = 1'b0;
        budget = 0;
        while (!out_valid && budget < 10) begin
            next_cycle();
            budget++;
        end
        @(negedge clk);
        if (!out_valid) timeout("t4_first_out");
        else chk("t4_first_out_data", 64'(out_data), 64'h222);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("t4_no_stale_word", 64'(out_valid), 64'd0);
        chk("t4_level_after", 64'(level), 64'd0);

        // Random traffic with scoreboard and level model
        next_cycle();
        model = 0;
        for (int c = 0; c < 2000; c++) begin
            r64 = {$urandom(), $urandom()};
            in_valid = ($urandom_range(0, 1) == 1);
            in_data = r64[DW-1:0];
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("t5_level", 64'(level), 64'(model));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    timeout("t5_underflow");
                end else begin
                    exp_w = q.pop_front();
                    chk("t5_data", 64'(out_data), 64'(exp_w));
                    model--;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                model++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 200) begin
            @(negedge clk);
            if (out_valid) begin
                exp_w = q.pop_front();
                chk("t5_drain_data", 64'(out_data), 64'(exp_w));
            end
            next_cycle();
            budget++;
        end
        if (q.size() != 0) timeout("t5_drain");
        @(negedge clk);
        chk("t5_final_level", 64'(level), 64'd0);
        chk("final_err", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
